// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared seven-segment glyph table and polarity helper
// Rev 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Lit-high patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t apply_pol(input seg_t bits, input logic active_low);
    return active_low ? ~bits : bits;
  endfunction

endpackage : display_pkg

`default_nettype wire

// File: rtl/hex_glyph.sv
// ============================================================================
// hex_glyph : combinational nibble to lit-high seven-segment pattern
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_glyph
  import display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule : hex_glyph

`default_nettype wire

// File: rtl/hex_scan_display.sv
// ============================================================================
// hex_scan_display : time-multiplexed N-digit seven-segment scan driver
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_scan_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*NUM_DIGITS-1:0]     value,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic                        blank_lz,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic                  SEG_POL = (SEG_ACTIVE_LOW != 0);
  localparam logic                  AN_POL  = (AN_ACTIVE_LOW != 0);
  localparam seg_t                  SEG_OFF = apply_pol(seg_t'(0), SEG_POL);
  localparam logic                  DP_OFF  = SEG_POL;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_POL}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_sh_q, val_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;

  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;

  logic [NUM_DIGITS:0]     zero_above;
  logic [NUM_DIGITS-1:0]   digit_dark;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_dark;
  logic [NUM_DIGITS-1:0]   an_onehot;
  seg_t                    sel_glyph;
  logic                    in_blank;
  logic                    lit;

  // Slot counter and scan index
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    val_sh_d = load ? value    : val_sh_q;
    dp_sh_d  = load ? dp_in    : dp_sh_q;
    en_sh_d  = load ? digit_en : en_sh_q;
  end

  // zero_above[k] is set when every shadow nibble at index >= k is zero
  always_comb begin
    zero_above             = '0;
    digit_dark             = '0;
    zero_above[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] & (val_sh_q[4*k +: 4] == 4'h0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_dark[k] = ~en_sh_q[k] | (blank_lz & zero_above[k] & (k != 0));
    end
  end

  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_dark  = 1'b1;
    an_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_nib      = val_sh_q[4*k +: 4];
        sel_dp       = dp_sh_q[k];
        sel_dark     = digit_dark[k];
        an_onehot[k] = 1'b1;
      end
    end
  end

  hex_glyph u_glyph (
    .nibble (sel_nib),
    .glyph  (sel_glyph)
  );

  // Polarity is the very last transform before the output register
  always_comb begin
    in_blank   = (int'(cnt_q) < BLANK_CYCLES);
    lit        = ~(in_blank | sel_dark);
    seg_d      = apply_pol(lit ? sel_glyph : seg_t'(0), SEG_POL);
    dp_d       = (lit & sel_dp) ^ SEG_POL;
    an_d       = (lit ? an_onehot : '0) ^ AN_OFF;
    scan_idx_d = idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      val_sh_q   <= '0;
      dp_sh_q    <= '0;
      en_sh_q    <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      an_q       <= AN_OFF;
      scan_idx_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      val_sh_q   <= val_sh_d;
      dp_sh_q    <= dp_sh_d;
      en_sh_q    <= en_sh_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;
  assign scan_idx = scan_idx_q;

endmodule : hex_scan_display

`default_nettype wire

// File: tb/tb_hex_scan_display.sv
// ============================================================================
// tb_hex_scan_display : directed self-checking bench for hex_scan_display
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hex_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  scan_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_scan_display #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .dp_in    (dp_in),
    .digit_en (digit_en),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .scan_idx (scan_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] es, input logic ed,
                       input logic [3:0] ea, input logic [1:0] ei);
    checks++;
    assert ({seg, dp, an, scan_idx} === {es, ed, ea, ei})
    else begin
      failures++;
      $error("FAIL %s: seg/dp/an/idx observed %b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, seg, dp, an, scan_idx, es, ed, ea, ei);
    end
  endtask

  task automatic check_dark(input string tag, input logic [1:0] ei);
    check(tag, 7'h7F, 1'b1, 4'hF, ei);
  endtask

  // Reset, then release with load so the shadows take the new inputs.
  // Returns just after the first post-reset edge (slot 0, blank cycle).
  task automatic reset_load(input string tag, input logic [15:0] v, input logic [3:0] en,
                            input logic [3:0] d, input logic lz);
    rst  = 1'b1;
    load = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    load     = 1'b1;
    value    = v;
    digit_en = en;
    dp_in    = d;
    blank_lz = lz;
    tick();
    check_dark({tag, "_r0"}, 2'd0);
    load = 1'b0;
  endtask

  // Tables packed {idx3,idx2,idx1,idx0}; pin level, active-low
  task automatic scan_slots(input string tag, input int nslots, input logic [27:0] seg_tab,
                            input logic [3:0] dp_tab, input logic [15:0] an_tab);
    for (int s = 0; s < nslots; s++) begin
      int k;
      k = s % 4;
      if (s != 0) begin
        tick();
        check_dark($sformatf("%s_s%0d_blank", tag, s), 2'(k));
      end
      for (int c = 1; c < 4; c++) begin
        tick();
        check($sformatf("%s_s%0d_c%0d", tag, s, c), seg_tab[7*k +: 7], dp_tab[k],
              an_tab[4*k +: 4], 2'(k));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with random inputs and load held high
    rst      = 1'b1;
    load     = 1'b1;
    value    = 16'($urandom);
    dp_in    = 4'($urandom);
    digit_en = 4'($urandom);
    blank_lz = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dark($sformatf("reset_c%0d", i), 2'd0);
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
    end
    rst  = 1'b0;
    load = 1'b0;
    tick();
    check_dark("reset_release", 2'd0);
    scan_slots("no_load", 2, {4{7'h7F}}, 4'hF, 16'hFFFF);

    // 2: basic scan of 1A3F, two full rotations
    reset_load("scan", 16'h1A3F, 4'hF, 4'h0, 1'b0);
    scan_slots("scan", 8, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110},
               4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

    // 3: leading-zero suppression
    reset_load("lz70", 16'h0070, 4'hF, 4'h0, 1'b1);
    scan_slots("lz70", 4, {7'h7F, 7'h7F, 7'b1111000, 7'b1000000},
               4'hF, {4'hF, 4'hF, 4'b1101, 4'b1110});
    reset_load("lz00", 16'h0000, 4'hF, 4'h0, 1'b1);
    scan_slots("lz00", 4, {7'h7F, 7'h7F, 7'h7F, 7'b1000000},
               4'hF, {4'hF, 4'hF, 4'hF, 4'b1110});

    // 4: digit enables and decimal points
    reset_load("endp", 16'h8888, 4'b0101, 4'b0100, 1'b0);
    scan_slots("endp", 4, {7'h7F, 7'b0000000, 7'h7F, 7'b0000000},
               4'b1011, {4'hF, 4'b1011, 4'hF, 4'b1110});

    // 5: load while idx1 is lit
    reset_load("ldmid", 16'h0030, 4'hF, 4'h0, 1'b0);
    scan_slots("ldmid", 1, {4{7'b1000000}}, 4'hF, {4{4'b1110}});
    tick();
    check_dark("ldmid_blank1", 2'd1);
    tick();
    check("ldmid_pre", 7'b0110000, 1'b1, 4'b1101, 2'd1);
    value = 16'h00E0;
    load  = 1'b1;
    tick();
    checks++;
    assert ({an, scan_idx} === {4'b1101, 2'd1})
    else begin
      failures++;
      $error("FAIL ldmid_edge: an/idx observed %b/%0d expected %b/%0d",
             an, scan_idx, 4'b1101, 2'd1);
    end
    load = 1'b0;
    tick();
    check("ldmid_post", 7'b0000110, 1'b1, 4'b1101, 2'd1);
    tick();
    check_dark("ldmid_blank2", 2'd2);
    tick();
    check("ldmid_idx2", 7'b1000000, 1'b1, 4'b1011, 2'd2);

    // 6: reset during idx2 cycle 2
    reset_load("rstmid", 16'h1A3F, 4'hF, 4'h0, 1'b0);
    scan_slots("rstmid", 2, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110},
               4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
    tick();
    check_dark("rstmid_blank2", 2'd2);
    tick();
    check("rstmid_c1", 7'b0001000, 1'b1, 4'b1011, 2'd2);
    tick();
    check("rstmid_c2", 7'b0001000, 1'b1, 4'b1011, 2'd2);
    rst = 1'b1;
    tick();
    check_dark("rstmid_in_reset", 2'd0);
    rst   = 1'b0;
    load  = 1'b1;
    value = 16'h1A3F;
    tick();
    check_dark("rstmid_release", 2'd0);
    load = 1'b0;
    scan_slots("rstmid_after", 2, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110},
               4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hex_scan_display

`default_nettype wire

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display. It is the parametrised successor to the single-digit hex glyph decoder. A snapshot of an N-nibble value is scanned one digit per refresh slot. Each slot gets an inter-digit blanking gap (anti-ghosting), per-digit enable, decimal points, optional leading-zero blanking, and configurable segment/anode polarity. It sits between the datapath registers and the board's shared segment bus.

Parameters:
NUM_DIGITS, 4, digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (0..REFRESH_DIV-1)
SEG_ACTIVE_LOW, 1, 1: segment/dp lit = 0; 0: lit = 1
AN_ACTIVE_LOW, 1, 1: anode selected = 0; 0: selected = 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
value  input  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost
load  input  1  capture value, dp_in and digit_en into the shadow registers this cycle
dp_in  input  NUM_DIGITS  decimal point request per digit
digit_en  input  NUM_DIGITS  1 = digit may light; 0 = forced blank
blank_lz  input  1  1 = suppress leading zeros (live, not shadowed)
seg  output  7  segments {g,f,e,d,c,b,a}
dp  output  1  decimal point
an  output  NUM_DIGITS  anode selects, one-hot when active
scan_idx  output  $clog2(NUM_DIGITS) (min 1)  digit index currently scanned (registered)

Behaviour:
- One clock, clk. rst is synchronous and active-high and overrides every other input, including load.
- Reset state:
  - slot counter = 0, scan index = 0, shadows = 0.
  - seg and dp at their unlit level (all 1 when active-low), an all deselected, scan_idx = 0.
- Slot counter: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index advances by 1. The index wraps from NUM_DIGITS-1 to 0.
- Glyph table (lit = 1 shown, before polarity):
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111
  - 4:1100110, 5:1101101, 6:1111101, 7:0000111
  - 8:1111111, 9:1101111, A:1110111, b:1111100
  - C:0111001, d:1011110, E:1111001, F:1110001
- Output computation:
  - seg, dp, an and scan_idx are registered from the current counter/index.
  - Latency is 1 cycle from a counter/index state to the pins.
- Digit k is dark (an deselected, seg and dp unlit) in any of these cases:
  - counter < BLANK_CYCLES;
  - digit_en shadow bit k = 0;
  - blank_lz = 1 and every shadow nibble at index >= k is 0, and k != 0.
  Digit 0 is never zero-suppressed.
- When lit: an is one-hot at k, seg = glyph(nibble k), dp = dp shadow bit k. Polarity is applied last.
- load: shadows update at the clock edge where load = 1. The next registered output uses the new shadow.
  - The scan position is unaffected; no restart.
  - load held high makes the block track value continuously.
- Reset mid-scan: outputs are unlit/deselected on the cycle after rst is sampled. Scanning restarts at digit 0, counter 0, on the first cycle rst is low.
- Between reset release and the first load, the display shows "0" on digit 0 only when enabled. After reset the digit_en shadow = 0, so all digits are dark.

Decomposition:
- Shared package (display_pkg):
  - 16-entry glyph constant array (lit-high form);
  - SEG_W = 7;
  - function apply_pol(bits, active_low).
- One natural sub-module: hex_glyph (combinational nibble -> 7-bit lit-high pattern), instantiated once on the selected nibble.
- Scan counter, shadows, leading-zero logic and the output register stay in the top.

Test Plan:
Common configuration for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, both polarities active-low.

1. Reset: rst=1 for 3 cycles with random inputs and load=1 -> seg=7'h7F, dp=1, an=4'hF, scan_idx=0. This holds every cycle of reset and the first cycle after release.
2. Scan: load value=16'h1A3F, digit_en=4'hF, dp_in=0, blank_lz=0. Within each 4-cycle slot, cycle 0 must have an=4'hF, and cycles 1-3 must show:
   - idx0: an=1110, seg=0001110;
   - idx1: an=1101, seg=0110000;
   - idx2: an=1011, seg=0001000;
   - idx3: an=0111, seg=1111001;
   - then wrap to idx0.
3. Leading zeros: value=16'h0070, blank_lz=1 -> during slots 3 and 2, an=4'hF; idx1 shows seg=1111000; idx0 shows seg=1000000. With value=0, only idx0 lights.
4. Enable/dp: value=16'h8888, digit_en=4'b0101, dp_in=4'b0100 -> idx1 and idx3 dark. idx0 shows seg=0000000, dp=1; idx2 shows seg=0000000, dp=0.
5. Load mid-slot: while idx1 is lit, load value=16'h00E0 -> from the next cycle seg=0000110 with an=1101 unchanged, and slot timing is undisturbed.
6. Reset mid-scan: assert rst during idx2, cycle 2 -> next cycle an=4'hF. After release the first slot is idx0 with its blank cycle first.
